// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write port shared by the W stage and a buffered long-latency unit
module wb_port_arbiter #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            LongValid,
  output logic            LongReady,
  input  logic [4:0]      LongRd,
  input  logic [XLEN-1:0] LongData,
  output logic            RegWriteOut,
  output logic [4:0]      RdOut,
  output logic [XLEN-1:0] WDataOut,
  output logic            StallWB,
  output logic [31:0]     PendingMask
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]      rd_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wptr, rptr, off;
  logic [AW:0]     count;
  logic [CW-1:0]   scnt, scnt_n;
  logic            starve_q, req, ne, forced, pop, push;
  assign req = RegWriteW && RdW != 5'd0;
  assign ne = count != '0;
  assign forced = starve_q && ne;
  assign pop = forced || (!req && ne);
  assign LongReady = count < (AW+1)'(DEPTH);
  assign push = LongValid && LongReady && LongRd != 5'd0;
  assign RegWriteOut = req || ne;
  assign StallWB = forced;
  assign RdOut = pop ? rd_mem[rptr] : req ? RdW : 5'd0;
  assign WDataOut = pop ? data_mem[rptr] : req ? ResultW : '0;
  assign scnt_n = (ne && !pop) ? (scnt == CW'(STARVE_LIMIT) ? scnt : scnt + 1'b1) : '0;
  // Entry i is live when its distance from the head is below count; the head drops out while popping
  always_comb begin
    PendingMask = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr;
      if ({1'b0, off} < count && !(pop && off == '0)) PendingMask[rd_mem[i]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr] <= LongRd;
      data_mem[wptr] <= LongData;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      scnt <= '0;
      starve_q <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      scnt <= scnt_n;
      starve_q <= scnt_n >= CW'(STARVE_LIMIT);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks against a queue-based model of the write-port arbiter
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 0, rst = 1;
  logic RegWriteW = 0, LongValid = 0, LongReady, RegWriteOut, StallWB;
  logic [4:0] RdW = 0, LongRd = 0, RdOut;
  logic [31:0] ResultW = 0, LongData = 0, WDataOut, PendingMask;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  int scnt = 0, checks = 0, failures = 0;
  bit starve = 0, last_stall = 0;

  wb_port_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LongValid(LongValid), .LongReady(LongReady), .LongRd(LongRd), .LongData(LongData),
    .RegWriteOut(RegWriteOut), .RdOut(RdOut), .WDataOut(WDataOut),
    .StallWB(StallWB), .PendingMask(PendingMask));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    scnt = 0;
    starve = 0;
    last_stall = 0;
  endtask

  // Expected outputs come straight from the grant priority rules applied to the model queue
  task automatic check_outputs();
    bit req, ne, forced, head;
    logic [31:0] mask;
    req = RegWriteW && RdW != 0;
    ne = q.size() > 0;
    forced = starve && ne;
    head = forced || (!req && ne);
    mask = 0;
    for (int i = head ? 1 : 0; i < q.size(); i++) mask[q[i].rd] = 1'b1;
    chk("we", 32'(RegWriteOut), 32'(req || ne));
    chk("rd", 32'(RdOut), head ? 32'(q[0].rd) : req ? 32'(RdW) : 0);
    chk("wdata", WDataOut, head ? q[0].d : req ? ResultW : 0);
    chk("stall", 32'(StallWB), 32'(forced));
    chk("ready", 32'(LongReady), 32'(q.size() < DEPTH));
    chk("mask", PendingMask, mask);
  endtask

  task automatic step(input bit rw, input logic [4:0] rd, input logic [31:0] res,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit req, ne, head, ready;
    @(negedge clk);
    RegWriteW = rw; RdW = rd; ResultW = res;
    LongValid = lv; LongRd = lrd; LongData = ld;
    #1 check_outputs();
    req = rw && rd != 0;
    ne = q.size() > 0;
    head = (starve && ne) || (!req && ne);
    ready = q.size() < DEPTH;
    last_stall = starve && ne;
    @(posedge clk);
    if (head) void'(q.pop_front());
    if (lv && ready && lrd != 0) q.push_back('{lrd, ld});
    scnt = (ne && !head) ? ((scnt + 1 > LIMIT) ? LIMIT : scnt + 1) : 0;
    starve = scnt >= LIMIT;
  endtask

  initial begin
    #1 chk("rst_we", 32'(RegWriteOut), 0);
    chk("rst_ready", 32'(LongReady), 1);
    chk("rst_mask", PendingMask, 0);
    chk("rst_stall", 32'(StallWB), 0);
    @(negedge clk) rst = 0;
    step(1, 5, 32'h1234, 0, 0, 0);
    step(0, 0, 0, 1, 7, 32'hAB);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h11, 1, 3, 32'h33);
    step(1, 2, 32'h22, 1, 4, 32'h44);
    step(1, 6, 32'h66, 1, 9, 32'h99);
    for (int i = 0; i < 8; i++) step(1, 6, 32'h66, last_stall ? 0 : 1, 9, 32'h99);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 8, 32'h80, 1, 10, 32'hA0);
    for (int i = 0; i < 7; i++) step(1, 8, 32'h80, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'hDEAD);
    step(1, 0, 32'h55, 1, 12, 32'hC0);
    step(1, 0, 32'h55, 0, 0, 0);
    step(1, 1, 32'h1, 1, 13, 32'hD0);
    step(1, 1, 32'h1, 1, 14, 32'hE0);
    @(negedge clk);
    RegWriteW = 0; LongValid = 0;
    #2 rst = 1;
    #1 model_reset();
    check_outputs();
    rst = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (last_stall) step(RegWriteW, RdW, ResultW, $urandom_range(0, 1), 5'($urandom), $urandom);
      else step($urandom_range(0, 9) < 8, 5'($urandom), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
